// File: rtl/sd_access_scheduler.sv
// Arbitrates the SD SPI controller between logging writes, FC reads and shutdown drain.
// A grant decided in IDLE/DRAIN becomes a one-cycle start pulse on the next cycle; one op is outstanding at a time.
module sd_access_scheduler #(
  parameter int          SECTOR_BYTES     = 512,
  parameter logic [31:0] START_SECTOR     = 32'd2048,
  parameter int          MAX_CONSEC_READS = 4,
  parameter int          TIMEOUT_CYCLES   = 10_500_000
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic        sd_init_done_p,
  input  logic [15:0] wr_fifo_count_p,
  input  logic        rd_req_p,
  input  logic        shutdown_req_p,
  input  logic        sd_op_done_p,
  input  logic        sd_op_error_p,
  output logic        sd_op_start_p,
  output logic [1:0]  sd_op_type_p,
  output logic [31:0] sd_op_addr_p,
  output logic [31:0] sd_sectors_written_p,
  output logic [31:0] sd_sectors_read_p,
  output logic [1:0]  shutdown_ready_p,
  output logic        timeout_flag_p,
  output logic [15:0] sched_status_p
);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_BUSY      = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam int             CR_W    = $clog2(MAX_CONSEC_READS + 1);
  localparam logic [CR_W-1:0] CR_MAX  = CR_W'(MAX_CONSEC_READS);

  state_e          state_q, state_d;
  logic [1:0]      op_type_q, op_type_d;
  logic [31:0]     op_addr_q, op_addr_d;
  logic [31:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]     rd_ptr_q, rd_ptr_d;
  logic [CR_W-1:0] consec_q, consec_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_ovf_q, rd_ovf_d;
  logic            rd_und_q, rd_und_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            timeout_q, timeout_d;
  logic            from_drain_q, from_drain_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic wr_elig, rd_elig, draining, done_ok, done_err;

  assign wr_elig  = wr_fifo_count_p >= 16'(SECTOR_BYTES);
  assign rd_elig  = rd_pend_q && ((consec_q < CR_MAX) || !wr_elig);
  assign done_ok  = (state_q == S_BUSY) && sd_op_done_p && !sd_op_error_p;
  assign done_err = (state_q == S_BUSY) && sd_op_done_p && sd_op_error_p;
  assign draining = (state_q == S_DRAIN) ||
                    (((state_q == S_ISSUE) || (state_q == S_BUSY)) && from_drain_q);

  always_comb begin
    state_d      = state_q;
    op_type_d    = op_type_q;
    op_addr_d    = op_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    consec_d     = consec_q;
    rd_pend_d    = rd_pend_q;
    rd_ovf_d     = rd_ovf_q;
    rd_und_d     = rd_und_q;
    err_cnt_d    = err_cnt_q;
    timeout_d    = timeout_q;
    from_drain_d = from_drain_q;
    wd_d         = wd_q;

    case (state_q)
      S_WAIT_INIT: begin
        if (sd_init_done_p) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!sd_init_done_p) begin
          state_d = S_WAIT_INIT;
        end else if (shutdown_req_p) begin
          state_d = S_DRAIN;
        end else if (rd_elig) begin
          if (rd_ptr_q == wr_ptr_q) begin
            rd_pend_d = 1'b0;
            rd_und_d  = 1'b1;
          end else begin
            op_type_d = OP_RD;
            op_addr_d = START_SECTOR + rd_ptr_q;
            wd_d      = '0;
            state_d   = S_ISSUE;
          end
        end else if (wr_elig) begin
          op_type_d = OP_WR;
          op_addr_d = START_SECTOR + wr_ptr_q;
          wd_d      = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = wd_q + WD_W'(1);
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (sd_op_done_p) begin
          op_type_d    = OP_NONE;
          from_drain_d = 1'b0;
          state_d      = (from_drain_q || shutdown_req_p) ? S_DRAIN : S_IDLE;
          if (done_ok && (op_type_q == OP_WR)) begin
            wr_ptr_d = wr_ptr_q + 32'd1;
            consec_d = '0;
          end else if (done_ok) begin
            rd_ptr_d  = rd_ptr_q + 32'd1;
            rd_pend_d = 1'b0;
            if (consec_q < CR_MAX) consec_d = consec_q + CR_W'(1);
          end else if (done_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          op_type_d = OP_NONE;
          state_d   = S_FAULT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DRAIN: begin
        if (!sd_init_done_p) begin
          state_d = S_WAIT_INIT;
        end else if (wr_elig) begin
          op_type_d    = OP_WR;
          op_addr_d    = START_SECTOR + wr_ptr_q;
          wd_d         = '0;
          from_drain_d = 1'b1;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (!sd_init_done_p)     state_d = S_WAIT_INIT;
        else if (!shutdown_req_p) state_d = S_IDLE;
      end
      default: state_d = S_FAULT;
    endcase

    // A read completing this cycle frees the request slot, so a pulse landing on it is kept.
    if (state_q == S_DRAIN) begin
      rd_pend_d = 1'b0;
    end else if (rd_req_p && !draining) begin
      if (rd_pend_q && !(done_ok && (op_type_q == OP_RD))) rd_ovf_d  = 1'b1;
      else                                                 rd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk210_p or negedge reset_p) begin
    if (!reset_p) begin
      state_q      <= S_WAIT_INIT;
      op_type_q    <= OP_NONE;
      op_addr_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      consec_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_ovf_q     <= 1'b0;
      rd_und_q     <= 1'b0;
      err_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      from_drain_q <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      op_type_q    <= op_type_d;
      op_addr_q    <= op_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      consec_q     <= consec_d;
      rd_pend_q    <= rd_pend_d;
      rd_ovf_q     <= rd_ovf_d;
      rd_und_q     <= rd_und_d;
      err_cnt_q    <= err_cnt_d;
      timeout_q    <= timeout_d;
      from_drain_q <= from_drain_d;
      wd_q         <= wd_d;
    end
  end

  always_comb begin
    shutdown_ready_p = 2'b00;
    if ((state_q == S_HALT) || (state_q == S_FAULT)) shutdown_ready_p = 2'b11;
    else if (draining)                               shutdown_ready_p = 2'b01;
  end

  assign sd_op_start_p        = (state_q == S_ISSUE);
  assign sd_op_type_p         = op_type_q;
  assign sd_op_addr_p         = op_addr_q;
  assign sd_sectors_written_p = wr_ptr_q;
  assign sd_sectors_read_p    = rd_ptr_q;
  assign timeout_flag_p       = timeout_q;
  assign sched_status_p       = {err_cnt_q, 2'b00, rd_und_q, rd_ovf_q, rd_pend_q, state_q};

endmodule
